// File: rtl/mem_copy_pkg.sv
// Shared definitions for the byte-copy engine: default widths and FSM state encoding.
package mem_copy_pkg;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } copy_state_e;

endpackage

// File: rtl/mem_copy.sv
// Memory-to-memory copy engine: one READ/WRITE cycle pair per byte, strictly ascending,
// single shared address port to a combinational-read data memory.
module mem_copy
   import mem_copy_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_wr_en,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   copy_state_e   state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] hold_q, hold_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   // Outputs decode purely from state so reset zeroes them without waiting for a clock.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr_en = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               src_d   = src;
               dst_d   = dst;
               cnt_d   = len;
               state_d = (len != '0) ? READ : DONE;
            end
         end
         READ: begin
            busy     = 1'b1;
            mem_addr = src_q;
            hold_d   = mem_rdata;
            state_d  = WRITE;
         end
         WRITE: begin
            busy      = 1'b1;
            mem_addr  = dst_q;
            mem_wdata = hold_q;
            mem_wr_en = 1'b1;
            src_d     = src_q + ONE;
            dst_d     = dst_q + ONE;
            cnt_d     = cnt_q - ONE;
            state_d   = (cnt_d != '0) ? READ : DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/mem_copy.md
MEM_COPY -- requirements
Module: mem_copy

Interface
REQ-001 Parameter: AW, 8, address width; the memory holds 2^AW bytes.
REQ-002 Parameter: DW, 8, data width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 Port: src  input  AW  source base address; captured when start is accepted.
REQ-007 Port: dst  input  AW  destination base address; captured when start is accepted.
REQ-008 Port: len  input  AW  byte count; captured when start is accepted; 0 means no transfer.
REQ-009 Port: mem_rdata  input  DW  combinational read data from the data memory at mem_addr.
REQ-010 Port: mem_addr  output  AW  address driven to the data memory.
REQ-011 Port: mem_wdata  output  DW  write data driven to the data memory.
REQ-012 Port: mem_wr_en  output  1  write strobe to the data memory.
REQ-013 Port: busy  output  1  high while in READ or WRITE.
REQ-014 Port: done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, READ, WRITE and DONE.
REQ-016 IDLE SHALL move to READ on start=1 with len!=0, and SHALL move to DONE on start=1 with len=0.
REQ-017 On acceptance, the block SHALL load the src pointer, the dst pointer and the remaining count from src, dst and len.
REQ-018 In READ, mem_addr SHALL equal the src pointer, mem_wr_en SHALL be 0, and mem_rdata SHALL be captured into a DW-bit hold register at the clock edge.
REQ-019 In READ, the next state SHALL always be WRITE.
REQ-020 In WRITE, mem_addr SHALL equal the dst pointer, mem_wdata SHALL equal the hold register, and mem_wr_en SHALL be 1 for exactly that cycle.
REQ-021 At the end of WRITE, both pointers SHALL increment by 1 modulo 2^AW (so 0xFF wraps to 0x00) and the count SHALL decrement by 1.
REQ-022 After WRITE, the next state SHALL be READ if the decremented count is nonzero, and DONE otherwise.
REQ-023 In DONE, done SHALL be 1 for one cycle and the next state SHALL be IDLE.
REQ-024 Timing: for len=N>0, busy SHALL be high for exactly 2N cycles, starting the cycle after start is sampled, followed by one cycle of done.
REQ-025 Timing: for len=0, done SHALL pulse on the cycle after start is sampled, busy SHALL stay 0, and no write SHALL occur.
REQ-026 start SHALL be ignored in READ, WRITE and DONE; src, dst and len changes while busy SHALL have no effect.
REQ-027 The copy SHALL be strictly ascending; for overlapping ranges with dst>src, source bytes already overwritten SHALL be re-read, with no correction.
REQ-028 In IDLE and DONE, mem_addr SHALL be 0, mem_wdata SHALL be 0 and mem_wr_en SHALL be 0.
REQ-029 mem_wr_en SHALL never be high outside WRITE.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and clear the pointers, count and hold register to 0.
REQ-031 rst_n=0 SHALL immediately drive busy, done, mem_wr_en, mem_addr and mem_wdata to 0.
REQ-032 Reset asserted mid-copy SHALL abort the copy with no further writes and no done pulse; bytes already written SHALL remain in memory.

Structure
REQ-033 The FSM state enum (IDLE, READ, WRITE, DONE) SHALL be defined in the shared processor package.
REQ-034 The default address and data widths SHALL be defined as constants in the same shared package.
REQ-035 mem_copy SHALL be a single module with no sub-modules.
REQ-036 The testbench SHALL instantiate the existing 256x8 data memory as the responder.

Verification
REQ-037 Scenario, basic copy: preload mem[0x10..0x13]=A1,B2,C3,D4; start with src=0x10, dst=0x40, len=4 -> mem[0x40..0x43]=A1,B2,C3,D4; busy high 8 cycles; done pulses once in the 9th cycle.
REQ-038 Scenario, zero length: len=0 -> done pulses the next cycle; busy stays 0; mem_wr_en never asserts.
REQ-039 Scenario, wrap-around: src=0xFE, dst=0x02, len=3, mem[0xFE,0xFF,0x00]=11,22,33 -> mem[0x02..0x04]=11,22,33.
REQ-040 Scenario, forward overlap: src=0x20, dst=0x21, len=3, mem[0x20]=5A -> mem[0x21..0x23]=5A,5A,5A.
REQ-041 Scenario, start while busy: assert start with new arguments during a len=4 copy -> ignored; exactly one done pulse; only the original destination is written.
REQ-042 Scenario, reset mid-copy: drop rst_n during the 3rd WRITE of a len=5 copy -> outputs go to 0 immediately; only 2 bytes are written; no done pulse; the next start runs normally.
